// File: rtl/led_count_checker.sv
// led_count_checker: monitors an 8-bit LED counter bus. Every change must be a
// +1 step (mod 256) arriving CLK_FREQ/2 cycles after the previous change, within
// TOL cycles. Reports per-step pulses, error class, lock status and statistics.
module led_count_checker #(
    parameter int unsigned CLK_FREQ = 10,
    parameter int unsigned TOL      = 0,
    localparam int unsigned W       = $clog2(CLK_FREQ + 2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   leds_in,
    output logic         step_ok,
    output logic         step_err,
    output logic [1:0]   err_code,
    output logic         locked,
    output logic [15:0]  good_count,
    output logic [7:0]   err_count,
    output logic [W-1:0] last_interval
);

    localparam int unsigned EXPECT = CLK_FREQ / 2;
    localparam logic [W-1:0] WIN_LO = W'(EXPECT - TOL);
    localparam logic [W-1:0] WIN_HI = W'(EXPECT + TOL);
    localparam logic [W-1:0] LIMIT  = W'(EXPECT + TOL + 1);

    localparam logic [1:0] CodeValue  = 2'b01;
    localparam logic [1:0] CodeTiming = 2'b10;
    localparam logic [1:0] CodeStall  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StLocked
    } state_e;

    state_e       state_q, state_d;
    logic [7:0]   leds_q;
    logic [W-1:0] iv_q, iv_d;
    logic         step_ok_q, step_ok_d;
    logic         step_err_q, step_err_d;
    logic [1:0]   err_code_q, err_code_d;
    logic [15:0]  good_count_q, good_count_d;
    logic [7:0]   err_count_q, err_count_d;
    logic [W-1:0] last_interval_q, last_interval_d;

    logic         chg;
    logic [7:0]   leds_inc;
    logic         value_ok;
    logic         timing_ok;

    assign chg       = (leds_in != leds_q);
    assign leds_inc  = leds_q + 8'd1;
    assign value_ok  = (leds_in == leds_inc);
    assign timing_ok = (iv_q >= WIN_LO) && (iv_q <= WIN_HI);

    // Interval counter: restarts at 1 on a change, otherwise counts up and saturates.
    always_comb begin
        iv_d = iv_q;
        if (chg) begin
            iv_d = W'(1);
        end else if (!(&iv_q)) begin
            iv_d = iv_q + W'(1);
        end
    end

    // Next-state and registered-output logic for the step checker.
    always_comb begin
        state_d         = state_q;
        step_ok_d       = 1'b0;
        step_err_d      = 1'b0;
        err_code_d      = err_code_q;
        good_count_d    = good_count_q;
        err_count_d     = err_count_q;
        last_interval_d = last_interval_q;
        unique case (state_q)
            StIdle: begin
                // First change only establishes the baseline.
                if (chg) begin
                    state_d = StSync;
                end
            end
            StSync, StLocked: begin
                if (chg) begin
                    last_interval_d = iv_q;
                    if (value_ok && timing_ok) begin
                        step_ok_d = 1'b1;
                        state_d   = StLocked;
                        if (good_count_q != 16'hFFFF) begin
                            good_count_d = good_count_q + 16'd1;
                        end
                    end else begin
                        step_err_d = 1'b1;
                        state_d    = StSync;
                        // A value error takes precedence when both checks fail.
                        err_code_d = value_ok ? CodeTiming : CodeValue;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end
                end else if (iv_q == LIMIT) begin
                    step_err_d = 1'b1;
                    err_code_d = CodeStall;
                    state_d    = StIdle;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset overrides any pending update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            leds_q          <= leds_in;
            iv_q            <= '0;
            step_ok_q       <= 1'b0;
            step_err_q      <= 1'b0;
            err_code_q      <= 2'b00;
            good_count_q    <= '0;
            err_count_q     <= '0;
            last_interval_q <= '0;
        end else begin
            state_q         <= state_d;
            leds_q          <= leds_in;
            iv_q            <= iv_d;
            step_ok_q       <= step_ok_d;
            step_err_q      <= step_err_d;
            err_code_q      <= err_code_d;
            good_count_q    <= good_count_d;
            err_count_q     <= err_count_d;
            last_interval_q <= last_interval_d;
        end
    end

    assign step_ok       = step_ok_q;
    assign step_err      = step_err_q;
    assign err_code      = err_code_q;
    assign locked        = (state_q == StLocked);
    assign good_count    = good_count_q;
    assign err_count     = err_count_q;
    assign last_interval = last_interval_q;

endmodule

// File: tb/tb_led_count_checker.sv
// tb_led_count_checker: drives two checkers (TOL=0 and TOL=1) with the same LED
// stimulus and compares every output each cycle against a timestamp-based model.
module tb_led_count_checker;

    localparam int CLK_FREQ = 10;
    localparam int W        = $clog2(CLK_FREQ + 2);
    localparam int EXPECT   = CLK_FREQ / 2;
    localparam int IVMAX    = (1 << W) - 1;

    logic                clk;
    logic                rst_n;
    logic [7:0]          leds_in;
    logic [1:0]          ok_w;
    logic [1:0]          err_w;
    logic [1:0][1:0]     code_w;
    logic [1:0]          lock_w;
    logic [1:0][15:0]    good_w;
    logic [1:0][7:0]     errc_w;
    logic [1:0][W-1:0]   last_w;

    led_count_checker #(.CLK_FREQ(CLK_FREQ), .TOL(0)) dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .leds_in       (leds_in),
        .step_ok       (ok_w[0]),
        .step_err      (err_w[0]),
        .err_code      (code_w[0]),
        .locked        (lock_w[0]),
        .good_count    (good_w[0]),
        .err_count     (errc_w[0]),
        .last_interval (last_w[0])
    );

    led_count_checker #(.CLK_FREQ(CLK_FREQ), .TOL(1)) dut1 (
        .clk           (clk),
        .rst_n         (rst_n),
        .leds_in       (leds_in),
        .step_ok       (ok_w[1]),
        .step_err      (err_w[1]),
        .err_code      (code_w[1]),
        .locked        (lock_w[1]),
        .good_count    (good_w[1]),
        .err_count     (errc_w[1]),
        .last_interval (last_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_miscmp;

    // Reference model: modes 0 idle, 1 tracking, 2 locked; timing from timestamps.
    int cyc;
    int m_tol    [2] = '{0, 1};
    int m_mode   [2];
    int m_prev   [2];
    int m_anchor [2];
    int m_ok     [2];
    int m_err    [2];
    int m_code   [2];
    int m_good   [2];
    int m_errc   [2];
    int m_last   [2];

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miscmp++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int iv;
            int nxt;
            bit vok, tok;
            m_ok[k]  = 0;
            m_err[k] = 0;
            if (!rst_n) begin
                m_mode[k]   = 0;
                m_prev[k]   = leds_in;
                m_anchor[k] = cyc + 1;
                m_code[k]   = 0;
                m_good[k]   = 0;
                m_errc[k]   = 0;
                m_last[k]   = 0;
            end else begin
                iv  = cyc - m_anchor[k];
                if (iv > IVMAX) iv = IVMAX;
                nxt = (m_prev[k] + 1) % 256;
                if (int'(leds_in) != m_prev[k]) begin
                    if (m_mode[k] != 0) begin
                        m_last[k] = iv;
                        vok = (int'(leds_in) == nxt);
                        tok = (iv >= EXPECT - m_tol[k]) && (iv <= EXPECT + m_tol[k]);
                        if (vok && tok) begin
                            m_ok[k]   = 1;
                            m_mode[k] = 2;
                            if (m_good[k] < 65535) m_good[k]++;
                        end else begin
                            m_err[k]  = 1;
                            m_mode[k] = 1;
                            m_code[k] = vok ? 2 : 1;
                            if (m_errc[k] < 255) m_errc[k]++;
                        end
                    end else begin
                        m_mode[k] = 1;
                    end
                    m_anchor[k] = cyc;
                end else if (m_mode[k] != 0 && iv == EXPECT + m_tol[k] + 1) begin
                    m_err[k]  = 1;
                    m_code[k] = 3;
                    m_mode[k] = 0;
                    if (m_errc[k] < 255) m_errc[k]++;
                end
                m_prev[k] = leds_in;
            end
        end
        cyc++;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            string p;
            p = (k == 0) ? "t0" : "t1";
            check({p, ".step_ok"},       int'(ok_w[k]),   m_ok[k]);
            check({p, ".step_err"},      int'(err_w[k]),  m_err[k]);
            check({p, ".err_code"},      int'(code_w[k]), m_code[k]);
            check({p, ".locked"},        int'(lock_w[k]), (m_mode[k] == 2) ? 1 : 0);
            check({p, ".good_count"},    int'(good_w[k]), m_good[k]);
            check({p, ".err_count"},     int'(errc_w[k]), m_errc[k]);
            check({p, ".last_interval"}, int'(last_w[k]), m_last[k]);
        end
    endtask

    // One clock: model sees the same inputs as the DUTs, outputs compared after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    // Apply a new value, then hold it for gap cycles (interval to next change = gap).
    task automatic step_to(input int v, input int gap);
        leds_in = 8'(v);
        tick(gap);
    endtask

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        leds_in  = 8'd0;
        tick(3);
        rst_n = 1'b1;
        tick(EXPECT);

        // Ideal counter 0..6, then value jump, early step, late step.
        for (int v = 1; v <= 6; v++) step_to(v, EXPECT);
        check("ideal.good_count", int'(good_w[0]), 5);
        check("ideal.locked", int'(lock_w[0]), 1);
        step_to(8, EXPECT);
        step_to(9, EXPECT - 1);
        step_to(10, EXPECT);
        step_to(11, EXPECT);
        step_to(12, EXPECT + 1);
        step_to(13, EXPECT);
        step_to(14, EXPECT);
        // Stall, then re-acquire.
        step_to(15, 3 * EXPECT);
        step_to(16, EXPECT);
        step_to(17, EXPECT);
        // Wrap 254 -> 255 -> 0.
        step_to(253, EXPECT);
        step_to(254, EXPECT);
        step_to(255, EXPECT);
        step_to(0, EXPECT);
        step_to(1, 2);
        // Reset mid-operation, then continue.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        step_to(1, EXPECT);
        step_to(2, EXPECT);
        step_to(3, EXPECT);

        // Randomized counter with occasional glitches, timing slips, stalls and resets.
        begin
            int v;
            v = 3;
            for (int s = 0; s < 600; s++) begin
                int r, gap;
                r = $urandom_range(0, 99);
                if (r < 65)      gap = EXPECT;
                else if (r < 92) gap = $urandom_range(EXPECT - 2, EXPECT + 2);
                else             gap = $urandom_range(EXPECT + 2, 3 * EXPECT);
                if ($urandom_range(0, 99) < 85) v = (v + 1) % 256;
                else                            v = $urandom_range(0, 255);
                if ($urandom_range(0, 99) < 2) begin
                    rst_n = 1'b0;
                    leds_in = 8'(v);
                    tick($urandom_range(1, 2));
                    rst_n = 1'b1;
                end
                step_to(v, gap);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/led_count_checker.md
# led_count_checker

Cycle-accurate monitor for the 8-bit LED counter bus. It samples `leds_in` in the same clock domain as the counter and checks every observed change. Each change must be a +1 step modulo 256 and must arrive CLK_FREQ/2 cycles after the previous change, within a tolerance. The block reports per-step pass/fail pulses, an error class, lock status and saturating statistics, and serves as the on-board self-check for the counter in the remote LED demo.

## Interface
- `CLK_FREQ`, default 10: clock cycles per second. Must match the counter under test. Must be ≥ 4.
- `TOL`, default 0: allowed deviation of the step interval, in cycles. Must be < CLK_FREQ/2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `leds_in` in 8: counter output under observation.
- `step_ok` out 1: one-cycle pulse; the last step was valid.
- `step_err` out 1: one-cycle pulse; the last step (or a stall) was invalid.
- `err_code` out 2: class of the last error. 00 none, 01 value, 10 timing, 11 stall. Held until the next error or reset.
- `locked` out 1: high while in LOCKED.
- `good_count` out 16: number of `step_ok` pulses, saturating at 65535.
- `err_count` out 8: number of `step_err` pulses, saturating at 255.
- `last_interval` out W: interval of the most recent checked change.
  - W = $clog2(CLK_FREQ+2).
  - The internal interval counter `iv` uses the same width W.

## Operation
- EXPECT = CLK_FREQ/2 (integer division). Valid interval window: EXPECT−TOL to EXPECT+TOL inclusive. LIMIT = EXPECT+TOL+1.
- `leds_q` registers `leds_in` every cycle. `chg` = (`leds_in` != `leds_q`), combinational.
- Interval counter `iv`:
  - On `chg`: `iv` ← 1.
  - Otherwise: `iv` ← `iv`+1, saturating at all-ones.
  - At a change cycle, `iv` equals the cycle distance to the previous change.
- Step checks, evaluated on `chg` in SYNC or LOCKED:
  - Value: `leds_in` == `leds_q`+1, 8-bit wrap, so 255→0 is valid.
  - Timing: `iv` is inside the window.
  - If both checks fail, the error is classed as a value error (code 01).
- State machine, states IDLE, SYNC, LOCKED:
  - IDLE, on `chg`: go to SYNC. No check, no pulse. This establishes the baseline.
  - SYNC or LOCKED, `chg` with both checks passing: `step_ok` pulse, `good_count`++, go to LOCKED.
  - SYNC or LOCKED, `chg` with a failing check: `step_err` pulse, `err_count`++, `err_code` set, go to SYNC. The new value becomes the new baseline.
  - SYNC or LOCKED, no `chg` and `iv` == LIMIT: `step_err` pulse with code 11, `err_count`++, go to IDLE.
- `last_interval` ← `iv` on every checked change (SYNC or LOCKED), pass or fail. It is not updated on stall.
- Reset values:
  - State IDLE.
  - `leds_q` ← `leds_in` (tracks the input while in reset, so no spurious change on release).
  - `iv` = 0.
  - All outputs 0.
- Reset asserted mid-operation overrides everything in that cycle. Any pulse pending from that cycle is dropped.

## Timing
- Change visible at `leds_in` in cycle N. `chg` is high in cycle N. `step_ok`/`step_err`, counters, `err_code`, `last_interval` and `locked` all update at the clock edge ending cycle N and are visible in N+1.
- Stall: change at cycle N with no further change. `step_err` is visible in cycle N+LIMIT+1.
- Pulses last exactly one cycle. `step_ok` and `step_err` are never high together.
- A counter that leaves reset at 0 and steps every EXPECT cycles behaves as follows:
  - First change: nothing reported.
  - Second change: `locked`=1.
  - Steady state: exactly one `step_ok` per EXPECT cycles.

## Test plan
All scenarios use CLK_FREQ=10, TOL=0, EXPECT=5.
1. Ideal counter 0→1→…→6, one step every 5 cycles → no pulse on 0→1. `step_ok` on every later step. `locked`=1 after 1→2. `good_count`=5. `last_interval`=5.
2. Locked, then jump 3→5 at the correct interval → `step_err`, `err_code`=01, `locked`=0, `err_count`=1. Next step 5→6 at interval 5 → `step_ok`, `locked`=1.
3. Locked, correct +1 step at interval 4 → `step_err`, `err_code`=10, `last_interval`=4. Same test with interval 6 and TOL=1 → `step_ok`.
4. Locked, value held after a change → `step_err` code 11, 7 cycles after the change. State IDLE, `locked`=0. Next change produces no pulse.
5. Locked, steps 254→255→0 at interval 5 → two `step_ok` pulses. Wrap is accepted.
6. Locked with nonzero counters, assert `rst_n`=0 for 1 cycle → all outputs 0, state IDLE. First change after release produces no pulse.
